// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if: data-memory bus between the memory stage and data memory.
//
// Signals (named from the memory stage's point of view):
//   dmem_req_o    request active
//   dmem_we_o     write enable (1 = store, 0 = load)
//   dmem_addr_o   word address
//   dmem_wdata_o  store data
//   dmem_ack_i    completion strobe from memory
//   dmem_rdata_i  read data, valid in the cycle dmem_ack_i is high
//
// Handshake: the requester raises dmem_req_o and holds dmem_we_o,
// dmem_addr_o and dmem_wdata_o constant until it samples dmem_ack_i = 1 on
// a rising edge. That edge completes the transfer, and dmem_rdata_i is taken
// on the same edge. While dmem_req_o is low, dmem_ack_i has no meaning.
//
// Modports:
//   master  memory stage (drives the request)
//   slave   data memory (drives ack and read data)
// ---------------------------------------------------------------------------
interface mem_stage_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              dmem_req_o;
   logic              dmem_we_o;
   logic [ADDR_W-1:0] dmem_addr_o;
   logic [DATA_W-1:0] dmem_wdata_o;
   logic              dmem_ack_i;
   logic [DATA_W-1:0] dmem_rdata_i;

   modport master (
      output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
      input  dmem_ack_i, dmem_rdata_i
   );

   modport slave (
      input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
      output dmem_ack_i, dmem_rdata_i
   );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage: pipeline memory stage.
//
// ALU instructions pass through to write-back with one cycle of latency.
// Loads and stores are captured, and the stage goes BUSY while it runs one
// data-memory transaction. The load result, or an empty store result, is
// then handed to write-back.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   valid_i, ld_i, st_i instruction valid and load/store control
//   addr_i, st_data_i   memory address and store data
//   alu_result_i        non-memory result
//   wb_en_i, dest_reg_addr_i  register write-back control
//   stall_o             upstream holds every *_i input while this is high
//   dmem                data-memory bus (mem_stage_if.master)
//   valid_o, wb_en_o, dest_reg_addr_o, wb_data_o  result to write-back
//   err_o               one-cycle pulse on memory timeout
//   dbg_state_o         current FSM state (0 = IDLE, 1 = BUSY)
//
// Handshake: an instruction is taken on a rising edge where valid_i = 1 and
// stall_o = 0. While stall_o = 1, upstream holds all inputs stable. valid_o
// is a single-cycle strobe per instruction and has no backpressure. The
// dmem bus follows the req/ack rules described in mem_stage_if.
//
// Build option: define MEM_STAGE_TIMEOUT_EN to abandon a memory request
// that has gone 255 BUSY cycles without an ack. The stage then pulses err_o
// and produces no result for that instruction. Without the macro, the stage
// waits for ack indefinitely and err_o is tied low.
// ---------------------------------------------------------------------------
module mem_stage #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 16,
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic                  ld_i,
   input  logic                  st_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic [DATA_W-1:0]     st_data_i,
   input  logic [DATA_W-1:0]     alu_result_i,
   input  logic                  wb_en_i,
   input  logic [REG_ADDR_W-1:0] dest_reg_addr_i,
   output logic                  stall_o,
   mem_stage_if.master           dmem,
   output logic                  valid_o,
   output logic                  wb_en_o,
   output logic [REG_ADDR_W-1:0] dest_reg_addr_o,
   output logic [DATA_W-1:0]     wb_data_o,
   output logic                  err_o,
   output logic                  dbg_state_o
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                state;
   // Write-back information captured when a memory op is accepted.
   logic                  cap_load;    // pure load: ld_i=1 and st_i=0
   logic                  cap_wb_en;
   logic [REG_ADDR_W-1:0] cap_dest;

`ifdef MEM_STAGE_TIMEOUT_EN
   // The counter reads k-1 in the k-th BUSY cycle. A value of 254 therefore
   // marks the 255th ack-less cycle, and that edge abandons the request.
   localparam logic [7:0] TMO_LAST = 8'd254;
   logic [7:0]            tmo_cnt;
`else
   assign err_o = 1'b0;
`endif

   assign dbg_state_o = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         stall_o           <= 1'b0;
         dmem.dmem_req_o   <= 1'b0;
         dmem.dmem_we_o    <= 1'b0;
         dmem.dmem_addr_o  <= '0;
         dmem.dmem_wdata_o <= '0;
         valid_o           <= 1'b0;
         wb_en_o           <= 1'b0;
         dest_reg_addr_o   <= '0;
         wb_data_o         <= '0;
         cap_load          <= 1'b0;
         cap_wb_en         <= 1'b0;
         cap_dest          <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
         tmo_cnt           <= '0;
         err_o             <= 1'b0;
`endif
      end else begin
`ifdef MEM_STAGE_TIMEOUT_EN
         err_o <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (valid_i && (ld_i || st_i)) begin
                  // A memory op. When ld_i and st_i are both high, the op
                  // is treated as a store.
                  state             <= BUSY;
                  stall_o           <= 1'b1;
                  dmem.dmem_req_o   <= 1'b1;
                  dmem.dmem_we_o    <= st_i;
                  dmem.dmem_addr_o  <= addr_i;
                  dmem.dmem_wdata_o <= st_data_i;
                  valid_o           <= 1'b0;
                  wb_en_o           <= 1'b0;
                  cap_load          <= ld_i & ~st_i;
                  cap_wb_en         <= wb_en_i;
                  cap_dest          <= dest_reg_addr_i;
`ifdef MEM_STAGE_TIMEOUT_EN
                  tmo_cnt           <= '0;
`endif
               end else if (valid_i) begin
                  valid_o         <= 1'b1;
                  wb_en_o         <= wb_en_i;
                  dest_reg_addr_o <= dest_reg_addr_i;
                  wb_data_o       <= alu_result_i;
               end else begin
                  valid_o <= 1'b0;
                  wb_en_o <= 1'b0;
               end
            end

            BUSY: begin
               valid_o <= 1'b0;
               if (dmem.dmem_ack_i) begin
                  state           <= IDLE;
                  stall_o         <= 1'b0;
                  dmem.dmem_req_o <= 1'b0;
                  dmem.dmem_we_o  <= 1'b0;
                  valid_o         <= 1'b1;
                  wb_en_o         <= cap_load & cap_wb_en;
                  dest_reg_addr_o <= cap_dest;
                  wb_data_o       <= cap_load ? dmem.dmem_rdata_i : '0;
               end
`ifdef MEM_STAGE_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  state           <= IDLE;
                  stall_o         <= 1'b0;
                  dmem.dmem_req_o <= 1'b0;
                  dmem.dmem_we_o  <= 1'b0;
                  wb_en_o         <= 1'b0;
                  err_o           <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
`endif
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage: self-checking bench for mem_stage.
// ---------------------------------------------------------------------------
module tb_mem_stage;
   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 16;
   localparam int REG_ADDR_W = 4;
   localparam int RES_W      = 2 + REG_ADDR_W + DATA_W;  // {is_store, wb_en, dest, data}
   localparam int REQ_W      = 1 + ADDR_W + DATA_W;      // {we, addr, wdata}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                  valid_i = 0, ld_i = 0, st_i = 0, wb_en_i = 0;
   logic [ADDR_W-1:0]     addr_i = '0;
   logic [DATA_W-1:0]     st_data_i = '0, alu_result_i = '0;
   logic [REG_ADDR_W-1:0] dest_reg_addr_i = '0;
   logic                  stall_o, valid_o, wb_en_o, err_o, dbg_state_o;
   logic [REG_ADDR_W-1:0] dest_reg_addr_o;
   logic [DATA_W-1:0]     wb_data_o;

   mem_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dmem ();

   // The memory side is driven either by directed code or by the responder.
   logic              auto_mem = 1'b0, rand_mon = 1'b0;
   logic              man_ack = 1'b0, r_ack = 1'b0;
   logic [DATA_W-1:0] man_rdata = '0, r_rdata = '0;
   assign dmem.dmem_ack_i   = auto_mem ? r_ack   : man_ack;
   assign dmem.dmem_rdata_i = auto_mem ? r_rdata : man_rdata;

   mem_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_ADDR_W(REG_ADDR_W)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ld_i(ld_i), .st_i(st_i),
      .addr_i(addr_i), .st_data_i(st_data_i), .alu_result_i(alu_result_i),
      .wb_en_i(wb_en_i), .dest_reg_addr_i(dest_reg_addr_i), .stall_o(stall_o),
      .dmem(dmem), .valid_o(valid_o), .wb_en_o(wb_en_o),
      .dest_reg_addr_o(dest_reg_addr_o), .wb_data_o(wb_data_o), .err_o(err_o),
      .dbg_state_o(dbg_state_o)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int failures = 0;
   logic [RES_W-1:0] exp_q[$];
   logic [REQ_W-1:0] req_q[$];
   logic [DATA_W-1:0] ref_mem[16];   // reference model's view of memory
   logic [DATA_W-1:0] mem_dmem[16];  // responder's memory contents

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, stall_o, 0);
      check({tag, "_req"}, dmem.dmem_req_o, 0);
      check({tag, "_we"}, dmem.dmem_we_o, 0);
      check({tag, "_addr"}, dmem.dmem_addr_o, 0);
      check({tag, "_wdata"}, dmem.dmem_wdata_o, 0);
      check({tag, "_valid"}, valid_o, 0);
      check({tag, "_wb_en"}, wb_en_o, 0);
      check({tag, "_dest"}, dest_reg_addr_o, 0);
      check({tag, "_wb_data"}, wb_data_o, 0);
      check({tag, "_err"}, err_o, 0);
      check({tag, "_state"}, dbg_state_o, 0);
   endtask

   task automatic drive(input logic v, input logic ld, input logic st, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] sd, input logic [DATA_W-1:0] alu,
                        input logic we, input logic [REG_ADDR_W-1:0] d);
      valid_i = v; ld_i = ld; st_i = st; addr_i = a; st_data_i = sd;
      alu_result_i = alu; wb_en_i = we; dest_reg_addr_i = d;
   endtask

   task automatic gen_instr();
      int kind;
      kind = $urandom_range(0, 3);
      drive($urandom_range(0, 9) < 8, kind == 1 || kind == 3, kind == 2 || kind == 3,
            ADDR_W'($urandom_range(0, 15)), $urandom, $urandom,
            1'($urandom_range(0, 1)), REG_ADDR_W'($urandom_range(0, 15)));
   endtask

   // Reference model: the result and memory request each accepted
   // instruction must eventually produce, in program order.
   task automatic model_accept();
      if (st_i) begin
         ref_mem[addr_i[3:0]] = st_data_i;
         exp_q.push_back({1'b1, 1'b0, {REG_ADDR_W{1'b0}}, {DATA_W{1'b0}}});
         req_q.push_back({1'b1, addr_i, st_data_i});
      end else if (ld_i) begin
         exp_q.push_back({1'b0, wb_en_i, dest_reg_addr_i, ref_mem[addr_i[3:0]]});
         req_q.push_back({1'b0, addr_i, st_data_i});
      end else begin
         exp_q.push_back({1'b0, wb_en_i, dest_reg_addr_i, alu_result_i});
      end
   endtask

   // ---------------- result monitor ----------------
   initial begin
      logic [RES_W-1:0] e;
      forever begin
         @(negedge clk);
         if (rand_mon) begin
            check("rand_valid_while_stall", valid_o & stall_o, 0);
            if (valid_o) begin
               if (exp_q.size() == 0) begin
                  check("rand_unexpected_valid", valid_o, 0);
               end else begin
                  e = exp_q.pop_front();
                  if (e[RES_W-1]) begin
                     check("rand_store_wb_en", wb_en_o, 0);
                     check("rand_store_wb_data", wb_data_o, 0);
                  end else begin
                     check("rand_result", {wb_en_o, dest_reg_addr_o, wb_data_o}, e[RES_W-2:0]);
                  end
               end
            end
         end
      end
   end

   // ---------------- memory responder ----------------
   initial begin
      logic             pend;
      int               wait_n;
      logic [REQ_W-1:0] cur_req, e;
      pend = 1'b0;
      wait_n = 0;
      cur_req = '0;
      forever begin
         @(negedge clk);
         if (auto_mem) begin
            if (dmem.dmem_req_o) begin
               if (!pend) begin
                  pend = 1'b1;
                  cur_req = {dmem.dmem_we_o, dmem.dmem_addr_o, dmem.dmem_wdata_o};
                  if (req_q.size() == 0) begin
                     check("rand_unexpected_req", dmem.dmem_req_o, 0);
                  end else begin
                     e = req_q.pop_front();
                     check("rand_req", cur_req, e);
                  end
                  wait_n = $urandom_range(0, 3);
               end else begin
                  check("rand_req_hold", {dmem.dmem_we_o, dmem.dmem_addr_o, dmem.dmem_wdata_o}, cur_req);
               end
               if (wait_n == 0) begin
                  r_ack = 1'b1;
                  if (dmem.dmem_we_o) begin
                     mem_dmem[dmem.dmem_addr_o[3:0]] = dmem.dmem_wdata_o;
                     r_rdata = $urandom;
                  end else begin
                     r_rdata = mem_dmem[dmem.dmem_addr_o[3:0]];
                  end
                  pend = 1'b0;
               end else begin
                  wait_n--;
                  r_ack = 1'b0;
                  r_rdata = $urandom;
               end
            end else begin
               // Random acks in IDLE must be ignored by the stage.
               r_ack = ($urandom_range(0, 3) == 0);
               r_rdata = $urandom;
            end
         end
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic                  valid;
      logic                  wb_en;
      logic                  ack;
      logic [REG_ADDR_W-1:0] dest;
      logic [DATA_W-1:0]     alu;
      logic                  e_valid;
      logic                  e_wb_en;
      logic [REG_ADDR_W-1:0] e_dest;
      logic [DATA_W-1:0]     e_data;
   } vec_t;

   vec_t vecs[6];

   // ---------------- main sequence ----------------
   initial begin
      logic acc;
      logic err_seen;
      logic req_drop;

      vecs[0] = '{1'b1, 1'b1, 1'b0, 4'd3,  32'h0000_1234, 1'b1, 1'b1, 4'd3,  32'h0000_1234};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 4'd8,  32'h0000_FFFF, 1'b0, 1'b0, 4'd3,  32'h0000_1234};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 4'd15, 32'hCAFE_F00D, 1'b1, 1'b0, 4'd15, 32'hCAFE_F00D};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 4'd0,  32'h0000_0000, 1'b1, 1'b1, 4'd0,  32'h0000_0000};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 4'd6,  32'h1111_2222, 1'b0, 1'b0, 4'd0,  32'h0000_0000};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 4'd7,  32'hFFFF_FFFF, 1'b1, 1'b1, 4'd7,  32'hFFFF_FFFF};

      // Reset
      rst = 1'b1;
      step();
      step();
      check_all_zero("reset");
      rst = 1'b0;

      // Single-cycle ALU/idle rows
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].valid, 1'b0, 1'b0, '0, '0, vecs[i].alu, vecs[i].wb_en, vecs[i].dest);
         man_ack = vecs[i].ack;
         man_rdata = 32'hBAD0_BAD0;
         step();
         check($sformatf("vec%0d_valid", i), valid_o, vecs[i].e_valid);
         check($sformatf("vec%0d_wb_en", i), wb_en_o, vecs[i].e_wb_en);
         check($sformatf("vec%0d_dest", i), dest_reg_addr_o, vecs[i].e_dest);
         check($sformatf("vec%0d_data", i), wb_data_o, vecs[i].e_data);
         check($sformatf("vec%0d_stall", i), stall_o, 0);
         check($sformatf("vec%0d_req", i), dmem.dmem_req_o, 0);
      end
      man_ack = 1'b0;

      // Load with ack on the third request cycle
      drive(1, 1, 0, 16'h0040, 32'h0, 32'h0, 1, 4'd5);
      step();
      drive(0, 0, 0, '0, '0, '0, 0, '0);
      for (int c = 1; c <= 3; c++) begin
         check($sformatf("ld_req_c%0d", c), {dmem.dmem_req_o, dmem.dmem_we_o, dmem.dmem_addr_o}, {2'b10, 16'h0040});
         check($sformatf("ld_stall_c%0d", c), stall_o, 1);
         check($sformatf("ld_valid_c%0d", c), valid_o, 0);
         if (c == 3) begin
            man_ack = 1'b1;
            man_rdata = 32'hDEAD_BEEF;
         end
         step();
      end
      man_ack = 1'b0;
      check("ld_res", {valid_o, wb_en_o, dest_reg_addr_o, wb_data_o}, {2'b11, 4'd5, 32'hDEAD_BEEF});
      check("ld_res_req_stall", {dmem.dmem_req_o, stall_o}, 0);
      step();
      check("ld_after_valid", valid_o, 0);

      // Store with ack on the first request cycle
      drive(1, 0, 1, 16'h0010, 32'h5555_AAAA, 32'h0, 1, 4'd4);
      step();
      drive(0, 0, 0, '0, '0, '0, 0, '0);
      check("st_req", {dmem.dmem_req_o, dmem.dmem_we_o, dmem.dmem_addr_o, dmem.dmem_wdata_o},
            {2'b11, 16'h0010, 32'h5555_AAAA});
      man_ack = 1'b1;
      man_rdata = 32'h1234_5678;
      step();
      man_ack = 1'b0;
      check("st_res", {valid_o, wb_en_o, wb_data_o}, {2'b10, 32'h0});
      check("st_res_req", dmem.dmem_req_o, 0);

      // Load followed by an ALU op held under stall
      drive(1, 1, 0, 16'h0020, 32'h0, 32'h0, 1, 4'd2);
      step();
      drive(1, 0, 0, '0, '0, 32'h0000_0077, 1, 4'd9);
      check("b2b_stall", stall_o, 1);
      man_ack = 1'b1;
      man_rdata = 32'h0000_1111;
      step();
      man_ack = 1'b0;
      check("b2b_ld_res", {valid_o, wb_en_o, dest_reg_addr_o, wb_data_o}, {2'b11, 4'd2, 32'h0000_1111});
      check("b2b_ld_stall", stall_o, 0);
      step();
      drive(0, 0, 0, '0, '0, '0, 0, '0);
      check("b2b_alu_res", {valid_o, wb_en_o, dest_reg_addr_o, wb_data_o}, {2'b11, 4'd9, 32'h0000_0077});
      step();
      check("b2b_no_dup", valid_o, 0);

      // Reset on the second BUSY cycle with ack high
      drive(1, 1, 0, 16'h0033, 32'h0, 32'h0, 1, 4'd1);
      step();
      drive(0, 0, 0, '0, '0, '0, 0, '0);
      step();
      check("rstbusy_state", dbg_state_o, 1);
      rst = 1'b1;
      man_ack = 1'b1;
      man_rdata = 32'hAAAA_0000;
      step();
      check_all_zero("rstbusy");
      rst = 1'b0;
      man_ack = 1'b0;
      step();
      check("rstbusy_after_valid", valid_o, 0);

      // No ack: timeout build abandons the request; default build waits
      drive(1, 0, 1, 16'h0005, 32'h0BAD_0BAD, 32'h0, 0, 4'd0);
      step();
      drive(0, 0, 0, '0, '0, '0, 0, '0);
      err_seen = 1'b0;
      req_drop = 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
      for (int c = 1; c < 255; c++) begin
         if (err_o) err_seen = 1'b1;
         if (!dmem.dmem_req_o) req_drop = 1'b1;
         step();
      end
      check("tmo_early", {err_seen, req_drop}, 0);
      check("tmo_c255_req", dmem.dmem_req_o, 1);
      step();
      check("tmo_err", err_o, 1);
      check("tmo_req", dmem.dmem_req_o, 0);
      check("tmo_valid_stall", {valid_o, stall_o}, 0);
      step();
      check("tmo_err_pulse", err_o, 0);
      check("tmo_state", dbg_state_o, 0);
`else
      for (int c = 1; c < 300; c++) begin
         if (err_o) err_seen = 1'b1;
         if (!dmem.dmem_req_o) req_drop = 1'b1;
         step();
      end
      check("noto_early", {err_seen, req_drop}, 0);
      check("noto_req_c300", {dmem.dmem_req_o, stall_o, err_o}, 3'b110);
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;

      // Randomized traffic against the reference model
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         mem_dmem[i] = ref_mem[i];
      end
      auto_mem = 1'b1;
      rand_mon = 1'b1;
      gen_instr();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         acc = valid_i && !stall_o;
         if (acc) model_accept();
         step();
         if (!acc && stall_o) begin
            // Inputs are held while the stage is stalled.
         end else begin
            gen_instr();
         end
      end
      // A stalled instruction must be allowed to finish before draining.
      for (int i = 0; i < 20 && stall_o; i++) begin
         @(negedge clk);
         acc = valid_i && !stall_o;
         if (acc) model_accept();
         step();
      end
      @(negedge clk);
      acc = valid_i && !stall_o;
      if (acc) model_accept();
      step();
      drive(0, 0, 0, '0, '0, '0, 0, '0);
      for (int i = 0; i < 200 && (exp_q.size() != 0 || stall_o); i++) @(negedge clk);
      @(negedge clk);
      check("drain_exp_q", exp_q.size(), 0);
      check("drain_req_q", req_q.size(), 0);
      rand_mon = 1'b0;
      auto_mem = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: DATA_W, 32, datapath width; ADDR_W, 16, data-memory word address width; REG_ADDR_W, 4, register-file address width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 valid_i  input  1  execute stage presents an instruction.
REQ-005 ld_i / st_i  input  1 each  load / store control from execute.
REQ-006 addr_i  input  ADDR_W  memory address computed by execute.
REQ-007 st_data_i  input  DATA_W  store data.
REQ-008 alu_result_i  input  DATA_W  non-memory result for write-back.
REQ-009 wb_en_i  input  1  instruction writes a register.
REQ-010 dest_reg_addr_i  input  REG_ADDR_W  destination register.
REQ-011 stall_o  output  1  upstream must hold all *_i stable while high.
REQ-012 dmem_req_o, dmem_we_o  output  1 each  memory request, write enable.
REQ-013 dmem_addr_o  output  ADDR_W; dmem_wdata_o  output  DATA_W.
REQ-014 dmem_ack_i  input  1; dmem_rdata_i  input  DATA_W  memory completion and read data.
REQ-015 valid_o, wb_en_o  output  1 each; dest_reg_addr_o  output  REG_ADDR_W; wb_data_o  output  DATA_W  to write-back stage.
REQ-016 err_o  output  1  one-cycle pulse on memory timeout.

Function
REQ-017 FSM states IDLE, BUSY; all outputs registered.
REQ-018 IDLE, valid_i=1, ld_i=st_i=0: next cycle valid_o=1, wb_en_o=wb_en_i, dest_reg_addr_o=dest_reg_addr_i, wb_data_o=alu_result_i (latency 1).
REQ-019 IDLE, valid_i=1, ld_i or st_i: capture inputs, go BUSY; next cycle dmem_req_o=1, dmem_we_o=st_i, dmem_addr_o=addr_i, dmem_wdata_o=st_data_i, valid_o=0.
REQ-020 ld_i and st_i both high: treated as store, no write-back.
REQ-021 stall_o=1 exactly while state is BUSY; IDLE accepts one instruction per cycle.
REQ-022 BUSY: dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o held constant until the cycle dmem_ack_i=1 is sampled; valid_o=0 every BUSY cycle.
REQ-023 Ack sampled in BUSY: next cycle state IDLE, dmem_req_o=0, stall_o=0, valid_o=1; load gives wb_en_o=captured wb_en_i, wb_data_o=dmem_rdata_i sampled with ack; store gives wb_en_o=0, wb_data_o=0.
REQ-024 dmem_ack_i is ignored in IDLE.
REQ-025 valid_i=0 in IDLE: next cycle valid_o=0, wb_en_o=0; other outputs hold.
REQ-026 Minimum memory-op occupancy: accept cycle, one request cycle, result cycle (ack on first request cycle gives valid_o 2 cycles after accept).

Reset
REQ-027 rst=1 at an edge: state IDLE; all outputs 0 after that edge, including mid-BUSY (request abandoned, dmem_req_o drops, no valid_o).
REQ-028 Reset priority over all other inputs, including dmem_ack_i in the same cycle.

Configuration
REQ-029 Macro MEM_STAGE_TIMEOUT_EN defined: 8-bit counter cleared on entering BUSY, incremented each BUSY cycle without ack; after 255 ack-less BUSY cycles, next cycle state IDLE, dmem_req_o=0, valid_o=0, err_o=1 for one cycle; ack in the same cycle as the limit completes normally.
REQ-030 Macro not defined: BUSY waits indefinitely, no counter, err_o tied 0.

Verification
REQ-031 ALU op, alu_result_i=0x0000_1234, dest=3, wb_en=1 -> next cycle valid_o=1, wb_data_o=0x0000_1234, dest_reg_addr_o=3, stall_o=0.
REQ-032 Load addr 0x0040, ack 3 cycles after req with rdata 0xDEAD_BEEF -> req held 3 cycles at 0x0040, stall_o high throughout, then valid_o=1, wb_en_o=1, wb_data_o=0xDEAD_BEEF.
REQ-033 Store addr 0x0010 data 0x5555_AAAA, ack on first request cycle -> dmem_we_o=1, dmem_wdata_o=0x5555_AAAA, then valid_o=1, wb_en_o=0.
REQ-034 Load then back-to-back ALU op held under stall -> ALU result emitted exactly one cycle after load result, no duplicate or lost instruction.
REQ-035 rst asserted on second BUSY cycle with ack high -> following cycle all outputs 0, state IDLE, no valid_o.
REQ-036 With MEM_STAGE_TIMEOUT_EN, no ack -> after 255 BUSY cycles err_o pulses once, dmem_req_o=0, valid_o=0; without macro, req still high at cycle 300.
